// File: rtl/unidade_pc_desvio.sv
// Program counter and fetch-redirect unit: advances the PC, applies branch/jump
// redirects with a one-cycle flush bubble, and counts applied redirects.
module unidade_pc_desvio #(
    parameter int unsigned           LARGURA_PC  = 8,
    parameter int unsigned           LARGURA_OFF = 5,
    parameter logic [LARGURA_PC-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   desvio,
    input  logic [LARGURA_PC-1:0]  pc_desvio,
    input  logic [LARGURA_OFF-1:0] offset,
    input  logic                   salto,
    input  logic [LARGURA_PC-1:0]  destino_salto,
    input  logic                   stall,
    input  logic                   halt,
    output logic [LARGURA_PC-1:0]  pc,
    output logic [LARGURA_PC-1:0]  pc_mais1,
    output logic                   valido,
    output logic                   flush,
    output logic [1:0]             estado,
    output logic [7:0]             contador_desvios
);

    localparam int unsigned            LARGURA_CNT = 8;
    localparam logic [LARGURA_CNT-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [LARGURA_PC-1:0]  pc_q, pc_d;
    logic [LARGURA_CNT-1:0] cnt_q, cnt_d;
    logic                   flush_q, flush_d;
    logic                   valido_q, valido_d;
    logic                   redireciona;
    logic [LARGURA_PC-1:0]  alvo_desvio;

    // Signed offset is sign-extended to PC width; the sum wraps naturally.
    assign alvo_desvio = pc_desvio + LARGURA_PC'($signed(offset));
    assign pc_mais1    = pc_q + LARGURA_PC'(1);

    // Next-state, next-PC and redirect accounting
    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        redireciona = 1'b0;

        unique case (estado_q)
            RUN: begin
                if (halt) begin
                    estado_d = HALT;
                end else if (desvio) begin
                    pc_d        = alvo_desvio;
                    estado_d    = FLUSH;
                    redireciona = 1'b1;
                end else if (salto) begin
                    pc_d        = destino_salto;
                    estado_d    = FLUSH;
                    redireciona = 1'b1;
                end else if (!stall) begin
                    pc_d = pc_mais1;
                end
            end
            FLUSH: begin
                // Execute slot is a bubble: requests in this cycle are dropped.
                estado_d = halt ? HALT : RUN;
            end
            HALT: begin
                estado_d = HALT;
            end
            default: begin
                estado_d = RUN;
            end
        endcase

        if (redireciona && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + LARGURA_CNT'(1);
        end

        flush_d  = (estado_d == FLUSH);
        valido_d = (estado_d == RUN);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            valido_q <= 1'b1;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            valido_q <= valido_d;
        end
    end

    assign pc               = pc_q;
    assign estado           = estado_q;
    assign flush            = flush_q;
    assign valido           = valido_q;
    assign contador_desvios = cnt_q;

endmodule

// File: tb/tb_unidade_pc_desvio.sv
// Self-checking bench for unidade_pc_desvio: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_unidade_pc_desvio;

    localparam logic [7:0] RST_PC = 8'hFE;

    logic       clock = 1'b0;
    logic       reset;
    logic       desvio;
    logic [7:0] pc_desvio;
    logic [4:0] offset;
    logic       salto;
    logic [7:0] destino_salto;
    logic       stall;
    logic       halt;
    logic [7:0] pc;
    logic [7:0] pc_mais1;
    logic       valido;
    logic       flush;
    logic [1:0] estado;
    logic [7:0] contador_desvios;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=RUN, 1=FLUSH, 2=HALT
    logic [7:0] m_pc;
    int         m_mode;
    int         m_cnt;

    logic [27:0] obs;
    assign obs = {pc, estado, flush, valido, contador_desvios, pc_mais1};

    unidade_pc_desvio #(
        .LARGURA_PC (8),
        .LARGURA_OFF(5),
        .RESET_PC   (RST_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .desvio          (desvio),
        .pc_desvio       (pc_desvio),
        .offset          (offset),
        .salto           (salto),
        .destino_salto   (destino_salto),
        .stall           (stall),
        .halt            (halt),
        .pc              (pc),
        .pc_mais1        (pc_mais1),
        .valido          (valido),
        .flush           (flush),
        .estado          (estado),
        .contador_desvios(contador_desvios)
    );

    always #5 clock = ~clock;

    function automatic int offset_int(input logic [4:0] o);
        return o[4] ? int'(o) - 32 : int'(o);
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [7:0] mais1;
        mais1 = 8'((int'(m_pc) + 1) % 256);
        return {m_pc, 2'(m_mode), 1'(m_mode == 1), 1'(m_mode == 0), 8'(m_cnt), mais1};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pc   = RST_PC;
            m_mode = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            if (halt) begin
                m_mode = 2;
            end else if (desvio || salto) begin
                m_pc   = desvio ? 8'((int'(pc_desvio) + offset_int(offset) + 256) % 256)
                                : destino_salto;
                m_mode = 1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (!stall) begin
                m_pc = 8'((int'(m_pc) + 1) % 256);
            end
        end else if (m_mode == 1) begin
            m_mode = halt ? 2 : 0;
        end
    endtask

    // Advance one clock edge, then let the model see the same inputs.
    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic idle();
        reset = 1'b0; desvio = 1'b0; salto = 1'b0; stall = 1'b0; halt = 1'b0;
        pc_desvio = 8'h00; offset = 5'h00; destino_salto = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== {RST_PC, 2'b00, 1'b0, 1'b1, 8'd0, 8'hFF}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, {RST_PC, 2'b00, 1'b0, 1'b1, 8'd0, 8'hFF});
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        logic [7:0] seq [3];
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== seq[i] || valido !== 1'b1) begin
                errors++;
                $display("FAIL free_run[%0d]: got pc=%h valido=%b expected pc=%h valido=1", i, pc, valido, seq[i]);
            end
            if (i == 0) begin
                checks++;
                if (pc_mais1 !== 8'h00) begin
                    errors++;
                    $display("FAIL pc_mais1_wrap: got %h expected 00", pc_mais1);
                end
            end
        end
    endtask

    task automatic test_branch();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40 && m_pc != 8'h12; i++) begin
            tick();
        end
        checks++;
        if (pc !== 8'h12) begin
            errors++;
            $display("FAIL reach_12: got %h expected 12", pc);
        end
        desvio = 1'b1; pc_desvio = 8'h10; offset = 5'b11101;
        tick();
        desvio = 1'b0;
        checks++;
        if ({pc, estado, flush, valido, contador_desvios} !== {8'h0D, 2'b01, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL branch_flush: got pc=%h est=%b fl=%b v=%b cnt=%0d expected pc=0d est=01 fl=1 v=0 cnt=1",
                     pc, estado, flush, valido, contador_desvios);
        end
        tick();
        checks++;
        if ({pc, estado, flush, valido} !== {8'h0D, 2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL branch_resume: got pc=%h est=%b fl=%b v=%b expected pc=0d est=00 fl=0 v=1",
                     pc, estado, flush, valido);
        end
        tick();
        checks++;
        if (pc !== 8'h0E || contador_desvios !== 8'd1) begin
            errors++;
            $display("FAIL branch_advance: got pc=%h cnt=%0d expected pc=0e cnt=1", pc, contador_desvios);
        end
    endtask

    task automatic test_simultaneous();
        int cnt0;
        cnt0 = m_cnt;
        desvio = 1'b1; pc_desvio = 8'h20; offset = 5'd4;
        salto = 1'b1; destino_salto = 8'h80; stall = 1'b1;
        tick();
        idle();
        checks++;
        if (pc !== 8'h24 || flush !== 1'b1 || int'(contador_desvios) != cnt0 + 1) begin
            errors++;
            $display("FAIL simultaneous: got pc=%h fl=%b cnt=%0d expected pc=24 fl=1 cnt=%0d",
                     pc, flush, contador_desvios, cnt0 + 1);
        end
        tick();
        checks++;
        if (obs !== exp_vec() || flush !== 1'b0 || pc !== 8'h24) begin
            errors++;
            $display("FAIL simultaneous_single_pulse: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_flush_ignore();
        int cnt0;
        cnt0 = m_cnt;
        desvio = 1'b1; pc_desvio = 8'h40; offset = 5'd0;
        tick();
        pc_desvio = 8'h50; offset = 5'd3; salto = 1'b1; destino_salto = 8'h99;
        tick();
        idle();
        checks++;
        if (pc !== 8'h40 || flush !== 1'b0 || estado !== 2'b00 || int'(contador_desvios) != cnt0 + 1) begin
            errors++;
            $display("FAIL flush_ignore: got pc=%h fl=%b est=%b cnt=%0d expected pc=40 fl=0 est=00 cnt=%0d",
                     pc, flush, estado, contador_desvios, cnt0 + 1);
        end
    endtask

    task automatic test_halt();
        salto = 1'b1; destino_salto = 8'h30;
        tick();
        salto = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        checks++;
        if ({pc, estado, flush, valido} !== {8'h30, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_enter: got pc=%h est=%b fl=%b v=%b expected pc=30 est=10 fl=0 v=0",
                     pc, estado, flush, valido);
        end
        for (int i = 0; i < 5; i++) begin
            desvio = 1'($urandom); salto = 1'($urandom); stall = 1'($urandom); halt = 1'($urandom);
            pc_desvio = 8'($urandom); offset = 5'($urandom); destino_salto = 8'($urandom);
            tick();
            checks++;
            if ({pc, estado, flush, valido} !== {8'h30, 2'b10, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got pc=%h est=%b fl=%b v=%b expected pc=30 est=10 fl=0 v=0",
                         i, pc, estado, flush, valido);
            end
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (pc !== RST_PC || estado !== 2'b00 || valido !== 1'b1) begin
            errors++;
            $display("FAIL halt_exit: got pc=%h est=%b v=%b expected pc=%h est=00 v=1", pc, estado, valido, RST_PC);
        end
    endtask

    task automatic test_reset_flush_saturation();
        salto = 1'b1; destino_salto = 8'h55;
        tick();
        checks++;
        if (flush !== 1'b1 || estado !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset_flush: got fl=%b est=%b expected fl=1 est=01", flush, estado);
        end
        salto = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (flush !== 1'b0 || estado !== 2'b00 || contador_desvios !== 8'd0 || pc !== RST_PC) begin
            errors++;
            $display("FAIL reset_in_flush: got fl=%b est=%b cnt=%0d pc=%h expected fl=0 est=00 cnt=0 pc=%h",
                     flush, estado, contador_desvios, pc, RST_PC);
        end
        salto = 1'b1;
        for (int i = 0; i < 520; i++) begin
            destino_salto = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL saturation_run[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
        idle();
        checks++;
        if (contador_desvios !== 8'd255) begin
            errors++;
            $display("FAIL counter_saturate: got %0d expected 255", contador_desvios);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            halt          = ($urandom_range(0, 99) < 3);
            desvio        = ($urandom_range(0, 99) < 25);
            salto         = ($urandom_range(0, 99) < 25);
            stall         = ($urandom_range(0, 99) < 20);
            pc_desvio     = 8'($urandom);
            offset        = 5'($urandom);
            destino_salto = 8'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_simultaneous();
        test_flush_ignore();
        test_halt();
        test_reset_flush_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
